// File: rtl/router_swreq_if.sv
// Port-side bundle between one router input port, its VC buffers, the four
// switch arbiters and the credit return path.
interface router_swreq_if #(
  parameter int unsigned NUM_VC     = 3,
  parameter int unsigned NO_OF_REQS = 15
);
  logic [NUM_VC-1:0]     vc_valid;
  logic [2*NUM_VC-1:0]   vc_route;
  logic [NO_OF_REQS-1:0] N_sw_arb_req;
  logic [NO_OF_REQS-1:0] S_sw_arb_req;
  logic [NO_OF_REQS-1:0] E_sw_arb_req;
  logic [NO_OF_REQS-1:0] W_sw_arb_req;
  logic [NO_OF_REQS-1:0] N_sw_arb_grant;
  logic [NO_OF_REQS-1:0] S_sw_arb_grant;
  logic [NO_OF_REQS-1:0] E_sw_arb_grant;
  logic [NO_OF_REQS-1:0] W_sw_arb_grant;
  logic [3:0]            credit_in;
  logic [NUM_VC-1:0]     vc_pop;
  logic                  xbar_vld;
  logic [1:0]            xbar_sel;
  logic                  credit_err;

  modport master (
    input  vc_valid, vc_route,
    input  N_sw_arb_grant, S_sw_arb_grant, E_sw_arb_grant, W_sw_arb_grant,
    input  credit_in,
    output N_sw_arb_req, S_sw_arb_req, E_sw_arb_req, W_sw_arb_req,
    output vc_pop, xbar_vld, xbar_sel, credit_err
  );

  modport slave (
    output vc_valid, vc_route,
    output N_sw_arb_grant, S_sw_arb_grant, E_sw_arb_grant, W_sw_arb_grant,
    output credit_in,
    input  N_sw_arb_req, S_sw_arb_req, E_sw_arb_req, W_sw_arb_req,
    input  vc_pop, xbar_vld, xbar_sel, credit_err
  );
endinterface

// File: rtl/router_swreq.sv
// Input-port switch request: round-robin VC pick, one request into the N/S/E/W
// arbiters, pop + crossbar select on grant, per-output downstream credit counters.
module router_swreq #(
  parameter int unsigned NO_OF_REQS = 15,
  parameter int unsigned NUM_VC     = 3,
  parameter int unsigned PORT_ID    = 0,
  parameter int unsigned CREDIT_W   = 3,
  parameter int unsigned MAX_CREDIT = 4
) (
  input  logic           Clk,
  input  logic           Rst,
  router_swreq_if.master bus
);
  localparam int unsigned VcW  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int unsigned Base = PORT_ID * NUM_VC;
  localparam logic [CREDIT_W-1:0] CreditMax = CREDIT_W'(MAX_CREDIT);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  logic [1:0]            r_state,     w_state_d;
  logic [VcW-1:0]        r_rr_ptr,    w_rr_d;
  logic [VcW-1:0]        r_cur_vc,    w_cur_vc_d;
  logic [1:0]            r_cur_out,   w_cur_out_d;
  logic [CREDIT_W-1:0]   r_credit [4];
  logic [CREDIT_W-1:0]   w_credit_d [4];
  logic [NO_OF_REQS-1:0] r_req [4];
  logic [NO_OF_REQS-1:0] w_req_d [4];
  logic [NUM_VC-1:0]     r_pop,       w_pop_d;
  logic                  r_xbar_vld,  w_xbar_vld_d;
  logic [1:0]            r_xbar_sel,  w_xbar_sel_d;
  logic                  r_credit_err, w_credit_err_d;

  logic [NUM_VC-1:0]     w_elig;
  logic                  w_found;
  logic [VcW-1:0]        w_pick_vc;
  logic [VcW-1:0]        w_idx;
  logic [1:0]            w_pick_out;
  logic [NO_OF_REQS-1:0] w_gnt_bus;
  logic                  w_gnt;
  logic [3:0]            w_dec;

  always_comb begin
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      w_elig[v] = bus.vc_valid[v] && (r_credit[bus.vc_route[2*v +: 2]] != '0);
    end
  end

  // First eligible VC at or after the round-robin pointer.
  always_comb begin
    w_found   = 1'b0;
    w_pick_vc = '0;
    w_idx     = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      w_idx = VcW'((32'(r_rr_ptr) + i) % NUM_VC);
      if (!w_found && w_elig[w_idx]) begin
        w_found   = 1'b1;
        w_pick_vc = w_idx;
      end
    end
  end

  assign w_pick_out = bus.vc_route[2*w_pick_vc +: 2];

  always_comb begin
    case (r_cur_out)
      2'd0:    w_gnt_bus = bus.N_sw_arb_grant;
      2'd1:    w_gnt_bus = bus.S_sw_arb_grant;
      2'd2:    w_gnt_bus = bus.E_sw_arb_grant;
      default: w_gnt_bus = bus.W_sw_arb_grant;
    endcase
  end

  // Only our own bit on the bus we requested counts as a grant.
  assign w_gnt = (r_state == StReq) &&
                 |(w_gnt_bus & (NO_OF_REQS'(1) << (Base + 32'(r_cur_vc))));
  assign w_dec = w_gnt ? (4'b0001 << r_cur_out) : 4'b0000;

  always_comb begin
    w_state_d    = r_state;
    w_rr_d       = r_rr_ptr;
    w_cur_vc_d   = r_cur_vc;
    w_cur_out_d  = r_cur_out;
    w_req_d      = '{default: '0};
    w_pop_d      = '0;
    w_xbar_vld_d = 1'b0;
    w_xbar_sel_d = 2'd0;
    case (r_state)
      StIdle: begin
        if (w_found) begin
          w_cur_vc_d          = w_pick_vc;
          w_cur_out_d         = w_pick_out;
          w_req_d[w_pick_out] = NO_OF_REQS'(1) << (Base + 32'(w_pick_vc));
          w_state_d           = StReq;
        end
      end
      StReq: begin
        if (w_gnt) begin
          w_pop_d      = NUM_VC'(1) << r_cur_vc;
          w_xbar_vld_d = 1'b1;
          w_xbar_sel_d = r_cur_out;
          w_rr_d       = (r_cur_vc == VcW'(NUM_VC - 1)) ? '0 : r_cur_vc + 1'b1;
          w_state_d    = StGap;
        end else if (bus.vc_valid[r_cur_vc]) begin
          w_req_d[r_cur_out] = r_req[r_cur_out];
        end else begin
          w_state_d = StIdle;
        end
      end
      StGap:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_credit_err_d = r_credit_err;
    for (int unsigned o = 0; o < 4; o++) begin
      w_credit_d[o] = r_credit[o];
      if (w_dec[o] && !bus.credit_in[o]) begin
        w_credit_d[o] = r_credit[o] - 1'b1;
      end else if (!w_dec[o] && bus.credit_in[o]) begin
        if (r_credit[o] == CreditMax) w_credit_err_d = 1'b1;
        else                          w_credit_d[o]  = r_credit[o] + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state      <= StIdle;
      r_rr_ptr     <= '0;
      r_cur_vc     <= '0;
      r_cur_out    <= 2'd0;
      r_credit     <= '{default: CreditMax};
      r_req        <= '{default: '0};
      r_pop        <= '0;
      r_xbar_vld   <= 1'b0;
      r_xbar_sel   <= 2'd0;
      r_credit_err <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_rr_ptr     <= w_rr_d;
      r_cur_vc     <= w_cur_vc_d;
      r_cur_out    <= w_cur_out_d;
      r_credit     <= w_credit_d;
      r_req        <= w_req_d;
      r_pop        <= w_pop_d;
      r_xbar_vld   <= w_xbar_vld_d;
      r_xbar_sel   <= w_xbar_sel_d;
      r_credit_err <= w_credit_err_d;
    end
  end

  assign bus.N_sw_arb_req = r_req[0];
  assign bus.S_sw_arb_req = r_req[1];
  assign bus.E_sw_arb_req = r_req[2];
  assign bus.W_sw_arb_req = r_req[3];
  assign bus.vc_pop       = r_pop;
  assign bus.xbar_vld     = r_xbar_vld;
  assign bus.xbar_sel     = r_xbar_sel;
  assign bus.credit_err   = r_credit_err;
endmodule

// File: tb/tb_router_swreq.sv
// Directed bench for router_swreq: dut1 (PORT_ID=1) with E grant tied to E request,
// dut0 (PORT_ID=0) with per-bus auto/forced grants.
module tb_router_swreq;
  logic Clk;
  logic Rst;
  int   checks = 0;
  int   errors = 0;

  logic [3:0]  auto0;
  logic [14:0] force0 [4];

  router_swreq_if #(.NUM_VC(3), .NO_OF_REQS(15)) if0 ();
  router_swreq_if #(.NUM_VC(3), .NO_OF_REQS(15)) if1 ();

  router_swreq #(.NO_OF_REQS(15), .NUM_VC(3), .PORT_ID(0), .CREDIT_W(3), .MAX_CREDIT(4))
    dut0 (.Clk(Clk), .Rst(Rst), .bus(if0.master));
  router_swreq #(.NO_OF_REQS(15), .NUM_VC(3), .PORT_ID(1), .CREDIT_W(3), .MAX_CREDIT(4))
    dut1 (.Clk(Clk), .Rst(Rst), .bus(if1.master));

  assign if0.N_sw_arb_grant = (auto0[0] ? if0.N_sw_arb_req : 15'h0) | force0[0];
  assign if0.S_sw_arb_grant = (auto0[1] ? if0.S_sw_arb_req : 15'h0) | force0[1];
  assign if0.E_sw_arb_grant = (auto0[2] ? if0.E_sw_arb_req : 15'h0) | force0[2];
  assign if0.W_sw_arb_grant = (auto0[3] ? if0.W_sw_arb_req : 15'h0) | force0[3];
  assign if1.N_sw_arb_grant = 15'h0;
  assign if1.S_sw_arb_grant = 15'h0;
  assign if1.E_sw_arb_grant = if1.E_sw_arb_req;
  assign if1.W_sw_arb_grant = 15'h0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    if0.vc_valid = '0; if0.vc_route = '0; if0.credit_in = '0;
    if1.vc_valid = '0; if1.vc_route = '0; if1.credit_in = '0;
    auto0 = '0;
    for (int i = 0; i < 4; i++) force0[i] = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    Rst = 1'b0;
    step();
    step();
    Rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++; if ({if0.N_sw_arb_req, if0.S_sw_arb_req, if0.E_sw_arb_req, if0.W_sw_arb_req} !== 60'h0) begin
      errors++; $display("FAIL rst_req0 got %h exp 0",
        {if0.N_sw_arb_req, if0.S_sw_arb_req, if0.E_sw_arb_req, if0.W_sw_arb_req}); end
    checks++; if ({if0.vc_pop, if0.xbar_vld, if0.xbar_sel, if0.credit_err} !== 7'h0) begin
      errors++; $display("FAIL rst_out0 got %h exp 0",
        {if0.vc_pop, if0.xbar_vld, if0.xbar_sel, if0.credit_err}); end
    checks++; if ({if1.vc_pop, if1.xbar_vld, if1.E_sw_arb_req} !== 19'h0) begin
      errors++; $display("FAIL rst_out1 got %h exp 0", {if1.vc_pop, if1.xbar_vld, if1.E_sw_arb_req}); end
    for (int o = 0; o < 4; o++) begin
      checks++; if (dut0.r_credit[o] !== 3'd4) begin
        errors++; $display("FAIL rst_credit%0d got %0d exp 4", o, dut0.r_credit[o]); end
    end
  endtask

  task automatic test_single();
    if1.vc_route = 6'b000010;
    if1.vc_valid = 3'b001;
    step();
    checks++; if (if1.E_sw_arb_req !== 15'h0008) begin
      errors++; $display("FAIL single_req got %h exp 0008", if1.E_sw_arb_req); end
    checks++; if ({if1.N_sw_arb_req, if1.S_sw_arb_req, if1.W_sw_arb_req} !== 45'h0) begin
      errors++; $display("FAIL single_other_req got %h exp 0",
        {if1.N_sw_arb_req, if1.S_sw_arb_req, if1.W_sw_arb_req}); end
    step();
    checks++; if ({if1.vc_pop, if1.xbar_vld, if1.xbar_sel} !== {3'b001, 1'b1, 2'd2}) begin
      errors++; $display("FAIL single_pop got %b exp 001_1_10", {if1.vc_pop, if1.xbar_vld, if1.xbar_sel}); end
    checks++; if (if1.E_sw_arb_req !== 15'h0) begin
      errors++; $display("FAIL single_req_drop got %h exp 0", if1.E_sw_arb_req); end
    checks++; if (dut1.r_credit[2] !== 3'd3) begin
      errors++; $display("FAIL single_credit got %0d exp 3", dut1.r_credit[2]); end
    if1.vc_valid = 3'b000;
    step();
    step();
  endtask

  task automatic test_rr();
    logic [2:0] exp_pop;
    auto0 = 4'b0001;
    if0.vc_route = 6'b000000;
    if0.vc_valid = 3'b111;
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_pop = 3'b000;
      if (c % 3 == 2) exp_pop = 3'(1 << (((c - 2) / 3) % 3));
      checks++; if (if0.vc_pop !== exp_pop) begin
        errors++; $display("FAIL rr_pop c%0d got %b exp %b", c, if0.vc_pop, exp_pop); end
    end
  endtask

  task automatic test_credit_stall();
    logic       found;
    logic [14:0] seen;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if ({if0.N_sw_arb_req, if0.vc_pop} !== 18'h0) begin
        errors++; $display("FAIL stall_idle c%0d got %h exp 0", c, {if0.N_sw_arb_req, if0.vc_pop}); end
    end
    checks++; if (dut0.r_credit[0] !== 3'd0) begin
      errors++; $display("FAIL stall_credit got %0d exp 0", dut0.r_credit[0]); end
    if0.credit_in = 4'b0001;
    step();
    if0.credit_in = 4'b0000;
    found = 1'b0;
    seen  = '0;
    for (int c = 0; c < 3 && !found; c++) begin
      step();
      if (if0.N_sw_arb_req !== 15'h0) begin
        found = 1'b1;
        seen  = if0.N_sw_arb_req;
      end
    end
    checks++; if (found !== 1'b1) begin
      errors++; $display("FAIL stall_reappear got %b exp 1", found); end
    checks++; if (seen !== 15'h0002) begin
      errors++; $display("FAIL stall_req got %h exp 0002", seen); end
    step();
    checks++; if (if0.vc_pop !== 3'b010) begin
      errors++; $display("FAIL stall_pop got %b exp 010", if0.vc_pop); end
    if0.vc_valid = 3'b000;
    auto0 = 4'b0000;
    step();
    step();
  endtask

  task automatic test_withhold();
    do_reset();
    if0.vc_route = 6'b000001;
    if0.vc_valid = 3'b001;
    step();
    checks++; if (if0.S_sw_arb_req !== 15'h0001) begin
      errors++; $display("FAIL hold_req0 got %h exp 0001", if0.S_sw_arb_req); end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if ({if0.S_sw_arb_req, if0.vc_pop} !== {15'h0001, 3'b000}) begin
        errors++; $display("FAIL hold_c%0d got %h exp %h", c, {if0.S_sw_arb_req, if0.vc_pop},
          {15'h0001, 3'b000}); end
    end
    if0.vc_valid = 3'b000;
    step();
    checks++; if ({if0.S_sw_arb_req, if0.vc_pop} !== 18'h0) begin
      errors++; $display("FAIL hold_withdraw got %h exp 0", {if0.S_sw_arb_req, if0.vc_pop}); end
    checks++; if (dut0.r_state !== 2'd0) begin
      errors++; $display("FAIL hold_state got %0d exp 0", dut0.r_state); end
  endtask

  task automatic test_slices();
    do_reset();
    if0.vc_route = 6'b000001;
    if0.vc_valid = 3'b001;
    step();
    force0[0] = 15'h0001;
    step();
    checks++; if ({if0.vc_pop, if0.S_sw_arb_req} !== {3'b000, 15'h0001}) begin
      errors++; $display("FAIL slice_wrongbus got %h exp %h", {if0.vc_pop, if0.S_sw_arb_req},
        {3'b000, 15'h0001}); end
    force0[0] = 15'h0;
    force0[1] = 15'h0020;
    step();
    checks++; if ({if0.vc_pop, if0.S_sw_arb_req} !== {3'b000, 15'h0001}) begin
      errors++; $display("FAIL slice_otherport got %h exp %h", {if0.vc_pop, if0.S_sw_arb_req},
        {3'b000, 15'h0001}); end
    force0[1] = 15'h0001;
    step();
    force0[1] = 15'h0;
    checks++; if ({if0.vc_pop, if0.xbar_vld, if0.xbar_sel} !== {3'b001, 1'b1, 2'd1}) begin
      errors++; $display("FAIL slice_pop got %b exp 001_1_01", {if0.vc_pop, if0.xbar_vld, if0.xbar_sel}); end
    if0.vc_valid = 3'b000;
    step();
    step();
  endtask

  task automatic test_credit_boundary();
    do_reset();
    if0.credit_in = 4'b0100;
    step();
    if0.credit_in = 4'b0000;
    checks++; if ({if0.credit_err, dut0.r_credit[2]} !== {1'b1, 3'd4}) begin
      errors++; $display("FAIL full_credit_in got %b exp 1_100", {if0.credit_err, dut0.r_credit[2]}); end
    step();
    step();
    checks++; if (if0.credit_err !== 1'b1) begin
      errors++; $display("FAIL err_sticky got %b exp 1", if0.credit_err); end
    do_reset();
    checks++; if (if0.credit_err !== 1'b0) begin
      errors++; $display("FAIL err_reset got %b exp 0", if0.credit_err); end
    auto0 = 4'b1000;
    if0.vc_route = 6'b000011;
    if0.vc_valid = 3'b001;
    step();
    checks++; if (if0.W_sw_arb_req !== 15'h0001) begin
      errors++; $display("FAIL simul_req got %h exp 0001", if0.W_sw_arb_req); end
    if0.credit_in = 4'b1000;
    step();
    if0.credit_in = 4'b0000;
    if0.vc_valid = 3'b000;
    checks++; if ({if0.vc_pop, dut0.r_credit[3], if0.credit_err} !== {3'b001, 3'd4, 1'b0}) begin
      errors++; $display("FAIL simul_credit got %b exp 001_100_0",
        {if0.vc_pop, dut0.r_credit[3], if0.credit_err}); end
    auto0 = 4'b0000;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    auto0 = 4'b1000;
    if0.vc_route = 6'b000011;
    if0.vc_valid = 3'b001;
    step();
    step();
    if0.vc_valid = 3'b000;
    auto0 = 4'b0000;
    step();
    if0.vc_route = 6'b000010;
    if0.vc_valid = 3'b001;
    step();
    checks++; if ({if0.E_sw_arb_req, dut0.r_credit[3]} !== {15'h0001, 3'd3}) begin
      errors++; $display("FAIL mid_pre got %h exp %h", {if0.E_sw_arb_req, dut0.r_credit[3]},
        {15'h0001, 3'd3}); end
    #2;
    Rst = 1'b0;
    #1;
    checks++; if (if0.E_sw_arb_req !== 15'h0) begin
      errors++; $display("FAIL mid_req got %h exp 0", if0.E_sw_arb_req); end
    checks++; if ({dut0.r_credit[3], dut0.r_state, if0.vc_pop} !== {3'd4, 2'd0, 3'b000}) begin
      errors++; $display("FAIL mid_state got %b exp 100_00_000",
        {dut0.r_credit[3], dut0.r_state, if0.vc_pop}); end
    if0.vc_valid = 3'b000;
    step();
    Rst = 1'b1;
    step();
  endtask

  initial begin
    clear_inputs();
    Rst = 1'b0;
    test_reset();
    test_single();
    test_rr();
    test_credit_stall();
    test_withhold();
    test_slices();
    test_credit_boundary();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/router_swreq.md
Name: router_swreq

Overview:
- Input-port side of switch allocation; one instance per router input port.
- Watches that port's VC buffer heads and picks at most one eligible VC per cycle, round-robin.
- Drives that VC's request bit into the N/S/E/W switch arbiters (one-hot 15-bit request buses, bit index = PORT_ID*NUM_VC + vc) and consumes the matching grant.
- On grant, pops the VC buffer, drives crossbar select and tracks downstream credits per output port.

Parameters:
- NO_OF_REQS, 15, width of each arbiter request/grant bus.
- NUM_VC, 3, VCs per input port.
- PORT_ID, 0, this input port's index (0..4); selects the owned slice [PORT_ID*NUM_VC +: NUM_VC].
- CREDIT_W, 3, credit counter width.
- MAX_CREDIT, 4, downstream buffer depth per output; reset value of each counter.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- vc_valid  in  NUM_VC  head flit present in VC v.
- vc_route  in  2*NUM_VC  output port of VC v's head flit at [2v+:2] (0=N, 1=S, 2=E, 3=W).
- N_sw_arb_req / S_sw_arb_req / E_sw_arb_req / W_sw_arb_req  out  NO_OF_REQS each  requests to the four arbiters.
- N_sw_arb_grant / S_sw_arb_grant / E_sw_arb_grant / W_sw_arb_grant  in  NO_OF_REQS each  grants from the four arbiters; the arbiters are combinational, so a grant is visible in the same cycle as its request.
- credit_in  in  4  one-cycle credit return per output, bit order N,S,E,W.
- vc_pop  out  NUM_VC  one-cycle dequeue pulse to VC v.
- xbar_vld  out  1  crossbar transfer this cycle.
- xbar_sel  out  2  output port for the transfer.
- credit_err  out  1  sticky: credit returned while the counter was at MAX_CREDIT.

Behaviour:
- Reset (Rst=0, async):
  - all req buses, vc_pop, xbar_vld, xbar_sel and credit_err = 0;
  - every credit counter = MAX_CREDIT;
  - rr_ptr = 0; state = IDLE.
- All outputs are registered. Request bits outside this port's slice are always 0.
- Eligibility of VC v: vc_valid[v]=1 and credit[vc_route[v]] > 0.
- FSM:
  - IDLE: if any VC is eligible, pick the first eligible VC at or after rr_ptr (wrapping modulo NUM_VC). Latch cur_vc and cur_out. Next cycle, assert exactly one bit, PORT_ID*NUM_VC+cur_vc, on the bus of cur_out. Go to REQ.
  - REQ, grant bit set on cur_out's bus at the sampling edge:
    - next cycle: vc_pop[cur_vc]=1, xbar_vld=1, xbar_sel=cur_out;
    - request deasserted; credit[cur_out] decremented;
    - rr_ptr = (cur_vc+1) mod NUM_VC;
    - go to GAP.
  - REQ, no grant, vc_valid[cur_vc] still 1: hold the request unchanged. No re-pick, because credits cannot fall while waiting.
  - REQ, vc_valid[cur_vc]=0: withdraw the request next cycle and go to IDLE. rr_ptr is unchanged.
  - GAP: one idle cycle so the VC FIFO head can advance, then IDLE.
- Best case: 1 grant per 3 cycles per input port (IDLE pick, REQ, GAP).
- Grant latency: the first pop follows 2 cycles after vc_valid rises, given credit and an immediate grant.
- Ignored grants: grant bits outside this port's slice, bits for a non-current VC, and any grant bit while not in REQ.
- Credits, per output:
  - same-cycle decrement and credit_in: counter unchanged;
  - credit_in at MAX_CREDIT with no decrement: counter stays at MAX_CREDIT and credit_err sets; it is cleared only by reset;
  - a counter never decrements below 0, because a VC whose route has zero credit is never requested.
- Mid-operation reset: all state returns to reset values at once. A request or pop in flight is dropped.

Test Plan:
- Reset, then PORT_ID=1, vc_valid=001, vc_route[1:0]=2, E_grant tied to E_req:
  - E_sw_arb_req=15'h0008 one cycle after vc_valid rises;
  - vc_pop=001, xbar_vld=1 and xbar_sel=2 the cycle after that;
  - credit[E] 4->3.
- PORT_ID=0, all three VCs valid routed N, grants immediate: pops in order VC0, VC1, VC2, VC0, one pop every 3 cycles.
- N credit drained with 4 grants and no credit_in: no N request while credit[N]=0. One credit_in[0] pulse -> request reappears within 2 cycles.
- Grant withheld 5 cycles: request stable for 5 cycles, no pop. Then drop vc_valid -> request 0 next cycle, state IDLE, no pop.
- Other-slice and wrong-bus grants:
  - PORT_ID=0, request on S, grant arrives on N_sw_arb_grant -> ignored;
  - grant on S bit 5 (another port's slice) -> ignored;
  - grant on S bit 0 -> pop.
- Boundary cases:
  - credit_in while the counter is full -> credit_err=1, counter stays 4;
  - simultaneous grant and credit_in -> counter unchanged;
  - Rst pulsed low while in REQ -> req bus 0 asynchronously, counters back to 4.
